barcode_tx: RTL and testbench

BARCODE_TX -- requirements
Module: barcode_tx

---
 rtl/barcode_tx.sv | 151 +++++++++++++++
 tb/tb_barcode_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/barcode_tx.sv
// rtl/barcode_tx.sv - pulse-width barcode serializer for an 8-bit station ID
module barcode_tx #(
    parameter int PERIOD_W = 22,
    parameter int MIN_Q    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                send,
    input  logic [7:0]          station_ID,
    input  logic [PERIOD_W-1:0] period,
    output logic                BC,
    output logic                busy,
    output logic                done
);

    localparam int QW = PERIOD_W - 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [QW-1:0]       MIN_Q_L = QW'(MIN_Q);
    localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

    logic [1:0]          state;
    logic [1:0]          nxt_state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] nxt_cnt;
    logic [2:0]          bit_cnt;
    logic [2:0]          nxt_bit;
    logic [7:0]          id_r;
    logic [7:0]          nxt_id;
    logic [QW-1:0]       q_r;
    logic [QW-1:0]       nxt_q;
    logic [QW-1:0]       q_in;

    logic [PERIOD_W-1:0] cell_last;
    logic                cell_end;
    logic [PERIOD_W-1:0] low_q1;
    logic [PERIOD_W-1:0] low_q2;
    logic [PERIOD_W-1:0] low_q3;
    logic                cur_bit;
    logic                nxt_bc;
    logic                nxt_done;

    // The two low bits of period never affect timing: cells are whole quarters.
    logic period_unused;
    assign period_unused = ^period[1:0];

    // Quarter length from the requested period, held at MIN_Q for short periods.
    always_comb begin
        q_in = period[PERIOD_W-1:2];
        if (q_in < MIN_Q_L) begin
            q_in = MIN_Q_L;
        end
    end

    // A cell is 4q cycles; cnt runs 0..4q-1 inside it.
    assign cell_last = {q_r, 2'b00} - ONE;
    assign cell_end  = (cnt == cell_last);

    // Frame sequencing: next state, cell/bit counters and captured frame parameters.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_bit   = bit_cnt;
        nxt_id    = id_r;
        nxt_q     = q_r;
        nxt_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (send) begin
                    nxt_state = S_START;
                    nxt_cnt   = '0;
                    nxt_bit   = '0;
                    nxt_id    = station_ID;
                    nxt_q     = q_in;
                end
            end
            S_START: begin
                if (cell_end) begin
                    nxt_state = S_DATA;
                    nxt_cnt   = '0;
                    nxt_bit   = '0;
                end else begin
                    nxt_cnt = cnt + ONE;
                end
            end
            S_DATA: begin
                if (cell_end) begin
                    nxt_cnt = '0;
                    if (bit_cnt == 3'd7) begin
                        nxt_state = S_GAP;
                    end else begin
                        nxt_bit = bit_cnt + 3'd1;
                    end
                end else begin
                    nxt_cnt = cnt + ONE;
                end
            end
            default: begin
                if (cell_end) begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_cnt = cnt + ONE;
                end
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from the next-state view so BC can be a flop.
    always_comb begin
        low_q1  = {2'b00, nxt_q};
        low_q2  = {1'b0, nxt_q, 1'b0};
        low_q3  = low_q1 + low_q2;
        cur_bit = nxt_id[3'd7 - nxt_bit];
        nxt_bc  = 1'b1;
        case (nxt_state)
            S_START: nxt_bc = (nxt_cnt >= low_q2);
            S_DATA:  nxt_bc = cur_bit ? (nxt_cnt >= low_q1) : (nxt_cnt >= low_q3);
            default: nxt_bc = 1'b1;
        endcase
    end

    // State, counters, captured parameters and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            id_r    <= '0;
            q_r     <= '0;
            BC      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            bit_cnt <= nxt_bit;
            id_r    <= nxt_id;
            q_r     <= nxt_q;
            BC      <= nxt_bc;
            busy    <= (nxt_state != S_IDLE);
            done    <= nxt_done;
        end
    end

endmodule

// File: tb/tb_barcode_tx.sv
// tb/tb_barcode_tx.sv - self-checking bench for barcode_tx
module tb_barcode_tx;

    localparam int PW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          send;
    logic [7:0]    station_ID;
    logic [PW-1:0] period;
    logic          BC;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    barcode_tx #(.PERIOD_W(PW), .MIN_Q(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .send       (send),
        .station_ID (station_ID),
        .period     (period),
        .BC         (BC),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic bc;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        int         period;
        logic [7:0] id;
        int         exp_q;
    } vec_t;

    exp_t sb[$];
    int   done_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_seen;
    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line behaviour for one whole frame plus its done cycle.
    task automatic push_frame(input int q, input logic [7:0] id);
        exp_t e;
        int   low;
        for (int c = 0; c < 4*q; c++) begin
            e.bc = (c >= 2*q); e.busy = 1'b1; e.done = 1'b0;
            sb.push_back(e);
        end
        for (int b = 7; b >= 0; b--) begin
            low = id[b] ? q : 3*q;
            for (int c = 0; c < 4*q; c++) begin
                e.bc = (c >= low); e.busy = 1'b1; e.done = 1'b0;
                sb.push_back(e);
            end
        end
        for (int c = 0; c < 4*q; c++) begin
            e.bc = 1'b1; e.busy = 1'b1; e.done = 1'b0;
            sb.push_back(e);
        end
        e.bc = 1'b1; e.busy = 1'b0; e.done = 1'b1;
        sb.push_back(e);
    endtask

    task automatic check_cycle();
        exp_t e;
        e = sb.pop_front();
        chk("wave", {29'd0, BC, busy, done}, {29'd0, e.bc, e.busy, e.done});
        if (busy === 1'b1) busy_seen++;
        if (done === 1'b1) done_cyc.push_back(cyc);
    endtask

    task automatic check_idle(input string name);
        chk(name, {29'd0, BC, busy, done}, 32'h4);
    endtask

    // Called at a negedge; leaves the bench at the negedge of the first frame cycle.
    task automatic start_frame(input int p, input logic [7:0] id, input int q);
        period     = PW'(p);
        station_ID = id;
        send       = 1'b1;
        push_frame(q, id);
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            check_cycle();
            @(negedge clk);
        end
    endtask

    initial begin
        int k;
        vecs[0] = '{16, 8'hA5, 4};
        vecs[1] = '{5,  8'hFF, 2};
        vecs[2] = '{4,  8'h3C, 2};
        vecs[3] = '{19, 8'h5A, 4};
        vecs[4] = '{0,  8'h00, 2};
        vecs[5] = '{11, 8'h81, 2};
        vecs[6] = '{12, 8'h0F, 3};

        rst = 1'b1; send = 1'b0; station_ID = 8'h00; period = PW'(16);
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        send = 1'b1;
        @(negedge clk);
        check_idle("reset_beats_send");
        rst = 1'b0; send = 1'b0;
        @(negedge clk);
        check_idle("idle_after_reset");

        // Table-driven single frames.
        for (int i = 0; i < 7; i++) begin
            busy_seen = 0;
            done_cyc.delete();
            start_frame(vecs[i].period, vecs[i].id, vecs[i].exp_q);
            drain();
            chk($sformatf("busy_len[%0d]", i), busy_seen, 40 * vecs[i].exp_q);
            chk($sformatf("done_count[%0d]", i), done_cyc.size(), 1);
            check_idle($sformatf("idle_after[%0d]", i));
        end

        // Retrigger during a frame with a new ID: ignored, not queued.
        busy_seen = 0;
        done_cyc.delete();
        start_frame(16, 8'hA5, 4);
        k = 0;
        while (sb.size() > 0) begin
            check_cycle();
            if (k == 29) begin
                send = 1'b1; station_ID = 8'h00;
            end else begin
                send = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        chk("retrig_busy_len", busy_seen, 160);
        chk("retrig_done_count", done_cyc.size(), 1);
        for (int i = 0; i < 5; i++) begin
            check_idle("retrig_no_second");
            @(negedge clk);
        end

        // send held high: back-to-back frames, ID switched in the done cycle.
        busy_seen = 0;
        done_cyc.delete();
        period = PW'(16); station_ID = 8'h3C; send = 1'b1;
        push_frame(4, 8'h3C);
        push_frame(4, 8'hC3);
        @(negedge clk);
        k = 0;
        while (sb.size() > 0) begin
            check_cycle();
            if (k == 160) station_ID = 8'hC3;
            if (k == 170) send = 1'b0;
            @(negedge clk);
            k++;
        end
        chk("b2b_busy_len", busy_seen, 320);
        chk("b2b_done_count", done_cyc.size(), 2);
        chk("b2b_done_gap", (done_cyc.size() >= 2) ? (done_cyc[1] - done_cyc[0]) : -1, 161);
        check_idle("b2b_idle_after");

        // Reset mid-frame while BC is low in data cell 3.
        done_cyc.delete();
        start_frame(16, 8'hA5, 4);
        for (int i = 0; i < 67; i++) begin
            check_cycle();
            @(negedge clk);
        end
        check_cycle();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_idle("rst_abandon");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle("rst_quiet");
        end
        chk("rst_no_done", done_cyc.size(), 0);
        busy_seen = 0;
        start_frame(16, 8'h96, 4);
        drain();
        chk("post_rst_busy_len", busy_seen, 160);
        chk("post_rst_done_count", done_cyc.size(), 1);
        check_idle("post_rst_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
